// File: rtl/core_pkg.sv
// Shared definitions for the core instruction packet and sequencer.
// Field positions, canned packets and sequencer states.
package core_pkg;

  localparam int INST_W = 34;
  localparam int A_W    = 11;

  localparam int ACC_B      = 33;
  localparam int CENP_B     = 32;
  localparam int WENP_B     = 31;
  localparam int AP_LSB     = 20;
  localparam int CENX_B     = 19;
  localparam int WENX_B     = 18;
  localparam int AX_LSB     = 7;
  localparam int OFIFO_RD_B = 6;
  localparam int IFIFO_WR_B = 5;
  localparam int IFIFO_RD_B = 4;
  localparam int L0_RD_B    = 3;
  localparam int L0_WR_B    = 2;
  localparam int EXEC_B     = 1;
  localparam int LOAD_B     = 0;

  localparam logic [INST_W-1:0] ONE = INST_W'(1);

  localparam logic [INST_W-1:0] IDLE_INST =
    (ONE << CENP_B) | (ONE << WENP_B) |
    (ONE << CENX_B) | (ONE << WENX_B);

  localparam logic [INST_W-1:0] LOAD_INST =
    IDLE_INST | (ONE << L0_RD_B) | (ONE << LOAD_B);

  localparam logic [INST_W-1:0] EXEC_INST =
    IDLE_INST | (ONE << L0_RD_B) | (ONE << EXEC_B);

  localparam logic [INST_W-1:0] OFRD_INST =
    IDLE_INST | (ONE << OFIFO_RD_B);

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_RD,
    S_W_LOAD,
    S_W_SETTLE,
    S_X_RD,
    S_X_EXEC,
    S_DRAIN_RD,
    S_DRAIN_WR,
    S_DONE
  } state_t;

endpackage

// File: rtl/core_inst_seq.sv
// Instruction sequencer: runs one weight-stationary tile per start,
// emitting registered 34-bit packets for the core datapath.
module core_inst_seq
  import core_pkg::*;
#(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] x_len,
  input  logic [ADDR_W-1:0] p_base,
  input  logic              acc_en,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam int KW = ADDR_W + 1;
  localparam logic [KW-1:0] ROW_K = KW'(row);
  localparam logic [KW-1:0] COL_K = KW'(col);

  // Packet address fields are fixed at 11 bits.
  generate
    if (ADDR_W != A_W || bw < 1 || row < 1 || col < 1) begin : g_bad_cfg
      $error("core_inst_seq: unsupported parameter set");
    end
  endgenerate

  state_t            state;
  logic [KW-1:0]     k;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] wb;
  logic [ADDR_W-1:0] xb;
  logic [ADDR_W-1:0] n;
  logic [ADDR_W-1:0] pb;
  logic              acc;

  logic [KW-1:0]     k_nx;
  logic [KW-1:0]     n_k;
  logic [ADDR_W-1:0] cnt_nx;

  assign k_nx   = k + 1'b1;
  assign n_k    = {1'b0, n};
  assign cnt_nx = cnt + 1'b1;

  // SRAM read phase: read for idx<len, L0 write lags by one cycle.
  function automatic logic [INST_W-1:0] rd_pkt(
    input logic [ADDR_W-1:0] base,
    input logic [KW-1:0]     idx,
    input logic [KW-1:0]     len
  );
    logic [INST_W-1:0] p;
    p = IDLE_INST;
    if (idx < len) begin
      p[CENX_B] = 1'b0;
      p[AX_LSB +: ADDR_W] = base + idx[ADDR_W-1:0];
    end
    p[L0_WR_B] = (idx != '0);
    return p;
  endfunction

  function automatic logic [INST_W-1:0] wr_pkt(
    input logic [ADDR_W-1:0] addr,
    input logic              a_acc
  );
    logic [INST_W-1:0] p;
    p = IDLE_INST;
    p[CENP_B] = 1'b0;
    p[WENP_B] = 1'b0;
    p[AP_LSB +: ADDR_W] = addr;
    p[ACC_B] = a_acc;
    return p;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      k     <= '0;
      cnt   <= '0;
      wb    <= '0;
      xb    <= '0;
      n     <= '0;
      pb    <= '0;
      acc   <= 1'b0;
      inst  <= IDLE_INST;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            wb    <= w_base;
            xb    <= x_base;
            n     <= x_len;
            pb    <= p_base;
            acc   <= acc_en;
            k     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            inst  <= rd_pkt(w_base, '0, ROW_K);
            state <= S_W_RD;
          end
        end
        S_W_RD: begin
          if (k < ROW_K) begin
            k    <= k_nx;
            inst <= rd_pkt(wb, k_nx, ROW_K);
          end else begin
            k     <= '0;
            inst  <= LOAD_INST;
            state <= S_W_LOAD;
          end
        end
        S_W_LOAD: begin
          if (k_nx < ROW_K) begin
            k    <= k_nx;
            inst <= LOAD_INST;
          end else begin
            k     <= '0;
            inst  <= IDLE_INST;
            state <= S_W_SETTLE;
          end
        end
        S_W_SETTLE: begin
          if (k_nx < COL_K) begin
            k    <= k_nx;
            inst <= IDLE_INST;
          end else if (n == '0) begin
            k     <= '0;
            inst  <= IDLE_INST;
            state <= S_DONE;
          end else begin
            k     <= '0;
            inst  <= rd_pkt(xb, '0, n_k);
            state <= S_X_RD;
          end
        end
        S_X_RD: begin
          if (k < n_k) begin
            k    <= k_nx;
            inst <= rd_pkt(xb, k_nx, n_k);
          end else begin
            k     <= '0;
            inst  <= EXEC_INST;
            state <= S_X_EXEC;
          end
        end
        S_X_EXEC: begin
          if (k_nx < n_k) begin
            k    <= k_nx;
            inst <= EXEC_INST;
          end else begin
            k     <= '0;
            cnt   <= '0;
            inst  <= IDLE_INST;
            state <= S_DRAIN_RD;
          end
        end
        // Valid is only looked at here, so one read per write pair.
        S_DRAIN_RD: begin
          if (ofifo_valid) begin
            inst  <= OFRD_INST;
            state <= S_DRAIN_WR;
          end else begin
            inst <= IDLE_INST;
          end
        end
        S_DRAIN_WR: begin
          inst  <= wr_pkt(pb + cnt, acc);
          cnt   <= cnt_nx;
          state <= (cnt_nx < n) ? S_DRAIN_RD : S_DONE;
        end
        S_DONE: begin
          inst  <= IDLE_INST;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          inst  <= IDLE_INST;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// Self-checking bench for core_inst_seq: directed and random tiles
// compared cycle by cycle against a packet-stream reference model.
module tb_core_inst_seq;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] w_base = '0;
  logic [AW-1:0] x_base = '0;
  logic [AW-1:0] x_len = '0;
  logic [AW-1:0] p_base = '0;
  logic          acc_en = 1'b0;
  logic          ofifo_valid = 1'b0;
  logic [33:0]   inst;
  logic          busy;
  logic          done;

  int total = 0;
  int passed = 0;
  int fails = 0;

  logic [33:0] e_inst[$];
  bit          vq[$];

  core_inst_seq #(
    .bw(4), .row(ROW), .col(COL), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .w_base(w_base),
    .x_base(x_base),
    .x_len(x_len),
    .p_base(p_base),
    .acc_en(acc_en),
    .ofifo_valid(ofifo_valid),
    .inst(inst),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [33:0] obs,
                       input logic [33:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] pk(
    input logic acc, input logic cenp, input logic wenp,
    input logic [AW-1:0] ap, input logic cenx, input logic [AW-1:0] ax,
    input logic ofr, input logic l0r, input logic l0w,
    input logic ex, input logic ld);
    return {acc, cenp, wenp, ap, cenx, 1'b1, ax,
            ofr, 1'b0, 1'b0, l0r, l0w, ex, ld};
  endfunction

  function automatic bit vat(input int j);
    return (j < vq.size()) ? vq[j] : 1'b1;
  endfunction

  task automatic gen_v(input int mode);
    vq.delete();
    for (int j = 0; j < 1024; j++) begin
      case (mode)
        0: vq.push_back(1'b1);
        1: vq.push_back($urandom_range(0, 1) == 1);
        default: vq.push_back((j % 9) > 4);
      endcase
    end
  endtask

  // Expected packet stream, one entry per cycle after the start edge.
  task automatic build(input logic [AW-1:0] wb, input logic [AW-1:0] xb,
                       input logic [AW-1:0] n, input logic [AW-1:0] pb,
                       input logic acc, output int didx);
    logic [33:0] idle;
    int j;
    idle = pk(0, 1, 1, '0, 1, '0, 0, 0, 0, 0, 0);
    e_inst.delete();
    for (int i = 0; i <= ROW; i++)
      e_inst.push_back(pk(0, 1, 1, '0, (i < ROW) ? 1'b0 : 1'b1,
        (i < ROW) ? wb + AW'(i) : '0, 0, 0, i > 0, 0, 0));
    for (int i = 0; i < ROW; i++)
      e_inst.push_back(pk(0, 1, 1, '0, 1, '0, 0, 1, 0, 0, 1));
    for (int i = 0; i < COL; i++)
      e_inst.push_back(idle);
    if (n != '0) begin
      for (int i = 0; i <= int'(n); i++)
        e_inst.push_back(pk(0, 1, 1, '0, (i < int'(n)) ? 1'b0 : 1'b1,
          (i < int'(n)) ? xb + AW'(i) : '0, 0, 0, i > 0, 0, 0));
      for (int i = 0; i < int'(n); i++)
        e_inst.push_back(pk(0, 1, 1, '0, 1, '0, 0, 1, 0, 1, 0));
      e_inst.push_back(idle);
      j = e_inst.size();
      for (int r = 0; r < int'(n); r++) begin
        while (!vat(j)) begin
          e_inst.push_back(idle);
          j++;
        end
        e_inst.push_back(pk(0, 1, 1, '0, 1, '0, 1, 0, 0, 0, 0));
        j++;
        e_inst.push_back(pk(acc, 0, 0, pb + AW'(r), 1, '0, 0, 0, 0, 0, 0));
        j++;
      end
    end else begin
      e_inst.push_back(idle);
    end
    e_inst.push_back(idle);
    didx = e_inst.size() - 1;
  endtask

  task automatic kick(input logic [AW-1:0] wb, input logic [AW-1:0] xb,
                      input logic [AW-1:0] n, input logic [AW-1:0] pb,
                      input logic acc);
    @(negedge clk);
    w_base = wb;
    x_base = xb;
    x_len = n;
    p_base = pb;
    acc_en = acc;
    start = 1'b1;
    ofifo_valid = vat(0);
  endtask

  task automatic run(input logic [AW-1:0] wb, input logic [AW-1:0] xb,
                     input logic [AW-1:0] n, input logic [AW-1:0] pb,
                     input logic acc, input int mode, input bit spur);
    int didx;
    int dut_done;
    int writes;
    int accbad;
    gen_v(mode);
    build(wb, xb, n, pb, acc, didx);
    kick(wb, xb, n, pb, acc);
    dut_done = -1;
    writes = 0;
    accbad = 0;
    for (int j = 0; j <= didx; j++) begin
      @(negedge clk);
      start = spur && (j == 3);
      w_base = AW'($urandom);
      x_base = AW'($urandom);
      x_len = AW'($urandom);
      p_base = AW'($urandom);
      check($sformatf("inst[%0d]", j), inst, e_inst[j]);
      check($sformatf("busy[%0d]", j), {33'b0, busy}, {33'b0, j < didx});
      check($sformatf("done[%0d]", j), {33'b0, done}, {33'b0, j == didx});
      if (done === 1'b1 && dut_done < 0) dut_done = j;
      if (inst[32] === 1'b0 && inst[31] === 1'b0) begin
        writes++;
        if (inst[33] !== acc) accbad++;
      end
      ofifo_valid = vat(j + 1);
    end
    start = 1'b0;
    @(negedge clk);
    check("post_idle", inst, 34'h1_800C_0000);
    check("post_busy", {33'b0, busy}, 34'd0);
    check("pmem_writes", 34'(writes), 34'(n));
    check("acc_bits", 34'(accbad), 34'd0);
    if (mode == 0 && n != '0)
      check("done_latency", 34'(dut_done), 34'(2 * ROW + COL + 4 * int'(n) + 3));
  endtask

  initial begin : main
    int didx;
    int mid;
    #1 reset = 1'b0;
    #2;
    check("reset_inst", inst, 34'h1_800C_0000);
    check("reset_busy", {33'b0, busy}, 34'd0);
    check("reset_done", {33'b0, done}, 34'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_inst", inst, 34'h1_800C_0000);

    run(11'h010, 11'h7FE, 11'd4, 11'h020, 1'b0, 0, 1'b0);
    run(AW'($urandom), AW'($urandom), 11'd5, AW'($urandom), 1'b0, 2, 1'b0);
    run(AW'($urandom), AW'($urandom), 11'd0, AW'($urandom), 1'b1, 0, 1'b0);
    run(AW'($urandom), AW'($urandom), 11'd3, AW'($urandom), 1'b1, 0, 1'b1);
    for (int t = 0; t < 6; t++)
      run(AW'($urandom), AW'($urandom), AW'($urandom_range(1, 7)),
          AW'($urandom), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    gen_v(0);
    build(11'h100, 11'h200, 11'd6, 11'h300, 1'b1, didx);
    kick(11'h100, 11'h200, 11'd6, 11'h300, 1'b1);
    mid = 2 * ROW + COL + 6 + 3;
    for (int j = 0; j <= mid; j++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("abort_inst[%0d]", j), inst, e_inst[j]);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_inst", inst, 34'h1_800C_0000);
    check("abort_busy", {33'b0, busy}, 34'd0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("abort_done", {33'b0, done}, 34'd0);
    end
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("after_abort_inst", inst, 34'h1_800C_0000);
      check("after_abort_busy", {33'b0, busy}, 34'd0);
      check("after_abort_done", {33'b0, done}, 34'd0);
    end

    run(11'h7F0, 11'h005, 11'd2, 11'h7FF, 1'b1, 1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/core_inst_seq.md
# core_inst_seq

Instruction sequencer for the `core` datapath. It generates the 34-bit `inst` packet that `core` consumes, so the testbench no longer hand-drives it. One `start` request runs one weight-stationary tile:
- read `row` weight vectors from activation SRAM into L0, then load them into the PE array;
- stream `x_len` activation vectors through L0 and execute them;
- drain the output FIFO and write each result vector into psum SRAM.

## Interface
- `bw`, 4: activation bit-width (informational; sets no logic here)
- `row`, 8: PE rows; weight vectors per tile
- `col`, 8: PE columns; settle cycles after weight load
- `ADDR_W`, 11: SRAM address width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `w_base`  in  ADDR_W  xmem address of weight vector 0
- `x_base`  in  ADDR_W  xmem address of activation vector 0
- `x_len`  in  ADDR_W  number of activation vectors N
- `p_base`  in  ADDR_W  pmem address of output vector 0
- `acc_en`  in  1  value driven on `inst[33]` during pmem writes
- `ofifo_valid`  in  1  high means at least one output vector is readable
- `inst`  out  34  instruction packet to `core`; registered
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse at tile completion

## Operation
- Packet fields:
  - `acc`[33], `CEN_pmem`[32], `WEN_pmem`[31], `A_pmem`[30:20]
  - `CEN_xmem`[19], `WEN_xmem`[18], `A_xmem`[17:7]
  - `ofifo_rd`[6], `ififo_wr`[5], `ififo_rd`[4], `l0_rd`[3], `l0_wr`[2], `execute`[1], `load`[0]
  - CEN and WEN are active-low.
- IDLE_INST = 34'h1_800C_0000: both CENs and WENs high, every other bit 0.
- `ififo_wr`/`ififo_rd`: always 0. `WEN_xmem`: always 1. The sequencer never writes xmem.
- On `start` in IDLE, latch all cfg inputs. `start` while busy is ignored.
- States and per-phase counter `k`:
  - W_RD, k=0..row: `CEN_xmem`=0 and `A_xmem`=w_base+k while k<row; `l0_wr`=1 while k≥1 (SRAM read latency is 1).
  - W_LOAD, k=0..row-1: `l0_rd`=1, `load`=1.
  - W_SETTLE, k=0..col-1: IDLE_INST.
  - X_RD, k=0..N: same as W_RD, using x_base.
  - X_EXEC, k=0..N-1: `l0_rd`=1, `execute`=1.
  - DRAIN_RD: if `ofifo_valid`=1, next `inst` has `ofifo_rd`=1 and the state goes to DRAIN_WR; otherwise hold IDLE_INST and stay.
  - DRAIN_WR: `CEN_pmem`=0, `WEN_pmem`=0, `A_pmem`=p_base+cnt, `acc`=acc_en, then cnt++. Return to DRAIN_RD while cnt<N, else go to DONE.
  - DONE: IDLE_INST, `done`=1, then IDLE.
- N=0: after W_SETTLE go straight to DONE. X_RD, X_EXEC and DRAIN are skipped.
- Address sums are modulo 2^ADDR_W and wrap silently.
- Any field not listed for a state takes its IDLE_INST value.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - state IDLE, all counters 0;
  - `inst`=IDLE_INST, `busy`=0, `done`=0.
- Reset mid-tile aborts the tile immediately. No partial pmem write may follow.
- `inst`, `busy` and `done` are flop outputs.
- Start latency: the first W_RD packet appears on `inst` in the cycle after `start` is sampled.
- Phase lengths: W_RD row+1, W_LOAD row, W_SETTLE col, X_RD N+1, X_EXEC N, DRAIN ≥2N cycles.
- Best case with `ofifo_valid` held high: `done` occurs 2·row+col+4N+3 cycles after the `start` edge.
- The drain reads at most one vector per 2 cycles. `ofifo_valid` is re-sampled only in DRAIN_RD, so the FIFO is never over-read.
- `busy` rises with the first W_RD packet and falls with `done`.

## Structure
- Shared package `core_pkg`:
  - `inst` bit-position localparams;
  - IDLE_INST constant;
  - state enum.
- Single module with no sub-modules. Counters and the FSM are small.

## Test plan
- Reset: drive `reset`=0 mid-X_EXEC -> `inst`=34'h1_800C_0000 and `busy`=0 asynchronously, no `done` pulse.
- Weight phase, row=8, w_base=0x10: `A_xmem` runs 0x10..0x17 with `CEN_xmem`=0; `l0_wr` is high one cycle delayed for 8 cycles; then 8 cycles with `load`=`l0_rd`=1; then 8 idle cycles.
- Full tile, N=4, x_base=0x7FE, p_base=0x20, `ofifo_valid` held 1:
  - `A_xmem` goes 0x7FE, 0x7FF, 0x000, 0x001 (wrap);
  - 4 `execute` cycles;
  - `A_pmem` goes 0x20..0x23;
  - `done` pulses 43 cycles after `start`.
- Drain backpressure: `ofifo_valid` low for 5 cycles between results -> no `ofifo_rd` and no pmem write during the gap; exactly N writes in total.
- N=0: no `execute`, `ofifo_rd` or pmem access; `done` follows W_SETTLE.
- `start` pulsed while busy, and `acc_en`=1 -> second start ignored; `inst[33]`=1 on every pmem write.
